alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter BITS, default 8, operand/result width (>=4, power of 2).
REQ-002 SHALL have parameter MUL_EN, default 1, which enables the sequential multiply.
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port op  input  3  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7.
REQ-008 SHALL have ports RA, RB  input  BITS  operands.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out  output  BITS  result, low half for MUL.
REQ-012 SHALL have port out_hi  output  BITS  MUL high half, 0 for other ops.
REQ-013 SHALL have ports carry_out, zero_flag, neg_flag, ovf_flag  output  1 each  status flags.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid && in_ready, latching op/RA/RB; later operand changes have no effect.
REQ-015 SHALL implement FSM states IDLE (no result pending), RUN (multiply iterating), DONE (out_valid=1).
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready=0 in RUN.
REQ-017 SHALL, for non-MUL ops accepted at edge T, go to DONE with out_valid=1 and all outputs registered after edge T (1-cycle latency).
REQ-018 SHALL, for MUL accepted at edge T, go to RUN for exactly BITS cycles using shift-add, reaching DONE after edge T+BITS.
REQ-019 SHALL hold out, out_hi and all flags stable in DONE until out_ready=1.
REQ-020 SHALL, in DONE with out_ready=1 and no new request, go to IDLE with out_valid=0.
REQ-021 SHALL, in DONE with out_ready=1 and in_valid=1, accept the new request in the same cycle: back-to-back non-MUL ops stay in DONE with no bubble; MUL goes to RUN with out_valid=0.
REQ-022 SHALL compute ADD as out = low BITS of RA+RB, with carry_out = bit BITS and ovf_flag = signed overflow.
REQ-023 SHALL compute SUB as out = RA-RB mod 2^BITS, with carry_out = borrow (RA<RB unsigned) and ovf_flag = signed overflow.
REQ-024 SHALL compute AND/OR/XOR bitwise, with carry_out=0 and ovf_flag=0.
REQ-025 SHALL implement SHL/SHR as logical shifts of RA by RB[$clog2(BITS)-1:0], with carry_out = last bit shifted out (0 for amount 0) and ovf_flag=0.
REQ-026 SHALL compute MUL as the unsigned 2*BITS product {out_hi,out}, with carry_out = (out_hi!=0), ovf_flag=0, zero_flag over the full product, and neg_flag=out_hi[BITS-1].
REQ-027 SHALL, for non-MUL ops, set zero_flag = (out==0), neg_flag = out[BITS-1] and out_hi=0.
REQ-028 SHALL, when MUL_EN=0, treat op 7 as a 1-cycle op returning out=0, out_hi=0, zero_flag=1 and other flags 0.

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge, force state IDLE, out_valid=0, out/out_hi=0, all flags 0, and clear the multiply counter.
REQ-030 SHALL abort any in-flight MUL on reset with no result ever presented; in_ready=1 on the first cycle after release.

Structure
REQ-031 SHALL take the op_e opcode enum, the state_e FSM enum and the opcode constants from shared package alu_pkg.
REQ-032 SHALL place the shift-add multiplier in sub-module alu_mul_seq (start, operands, done, 2*BITS product).

Verification (BITS=8)
REQ-033 SHALL verify ADD 0xFF+0x01 -> after 1 edge out=0x00, carry=1, zero=1, ovf=0, out_valid=1.
REQ-034 SHALL verify SUB 0x80-0x01 -> 0x7F, carry=0, ovf=1, neg=0; and SUB 0x03-0x05 -> 0xFE, carry=1, neg=1.
REQ-035 SHALL verify MUL 0xFF*0xFF -> out=0x01, out_hi=0xFE, carry=1, out_valid exactly 8 edges after accept, in_ready=0 throughout RUN.
REQ-036 SHALL verify backpressure: out_ready=0 for 5 cycles -> outputs frozen, in_ready=0; then out_ready=1 with XOR 0xF0^0x3C queued -> 0xCC on the next edge, no bubble.
REQ-037 SHALL verify SHL 0x81 by 1 -> 0x02, carry=1; and SHL by 0 -> 0x81, carry=0.
REQ-038 SHALL verify rst_n=0 on the 4th RUN cycle of a MUL -> next edge all outputs 0 and IDLE, with no stale out_valid after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
// Also holds the status-flag bundle that the top module registers alongside each result.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle for BITS cycles.
// done_o flags the final iteration so the caller can register product_o on that same edge.
module alu_mul_seq #(
  parameter int BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [BITS-1:0]   a_i,
  input  logic [BITS-1:0]   b_i,
  output logic              done_o,
  output logic [2*BITS-1:0] product_o
);

  localparam int CW = $clog2(BITS);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [2*BITS-1:0] acc_q, mcand_q, acc_nx;
  logic [BITS-1:0]   mplier_q;

  always_comb begin
    acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{BITS{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(BITS - 1)) busy_q <= 1'b0;
    end
  end

  assign done_o    = busy_q && (cnt_q == CW'(BITS - 1));
  assign product_o = acc_nx;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an optional multi-cycle multiply.
// Results and flags are registered and held in DONE until the consumer accepts them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [BITS-1:0] RA,
  input  logic [BITS-1:0] RB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out,
  output logic [BITS-1:0] out_hi,
  output logic            carry_out,
  output logic            zero_flag,
  output logic            neg_flag,
  output logic            ovf_flag
);

  localparam int SHW = $clog2(BITS);
  localparam int M   = BITS - 1;

  state_e            state_q, state_d;
  logic [BITS-1:0]   out_q, out_d, out_hi_q, out_hi_d, alu_res;
  flags_t            flags_q, flags_d, alu_flags, mul_flags;
  logic              accept, is_mul, mul_done;
  logic [2*BITS-1:0] mul_prod;
  logic [BITS:0]     sum, diff, shl_w, shr_w;
  logic [SHW-1:0]    amt;

  assign accept = in_valid && in_ready;
  assign is_mul = (op == OP_MUL) && (MUL_EN != 0);

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.BITS(BITS)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul),
        .a_i       (RA),
        .b_i       (RB),
        .done_o    (mul_done),
        .product_o (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    amt       = RB[SHW-1:0];
    sum       = {1'b0, RA} + {1'b0, RB};
    diff      = {1'b0, RA} - {1'b0, RB};
    shl_w     = {1'b0, RA} << amt;
    shr_w     = {RA, 1'b0} >> amt;
    alu_res   = '0;
    alu_flags = '0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res         = sum[M:0];
        alu_flags.carry = sum[BITS];
        alu_flags.ovf   = (RA[M] == RB[M]) && (sum[M] != RA[M]);
      end
      OP_SUB: begin
        alu_res         = diff[M:0];
        alu_flags.carry = diff[BITS];
        alu_flags.ovf   = (RA[M] != RB[M]) && (diff[M] != RA[M]);
      end
      OP_AND: alu_res = RA & RB;
      OP_OR:  alu_res = RA | RB;
      OP_XOR: alu_res = RA ^ RB;
      OP_SHL: begin
        alu_res         = shl_w[M:0];
        alu_flags.carry = shl_w[BITS];
      end
      OP_SHR: begin
        alu_res         = shr_w[BITS:1];
        alu_flags.carry = shr_w[0];
      end
      default: alu_res = '0;  // op 7 only reaches here with the multiplier disabled
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[M];

    mul_flags       = '0;
    mul_flags.carry = (mul_prod[2*BITS-1:BITS] != '0);
    mul_flags.zero  = (mul_prod == '0);
    mul_flags.neg   = mul_prod[2*BITS-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_mul ? S_RUN : S_DONE;
      S_RUN:  if (mul_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = accept ? (is_mul ? S_RUN : S_DONE) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    out_d    = out_q;
    out_hi_d = out_hi_q;
    flags_d  = flags_q;
    if (accept && !is_mul) begin
      out_d    = alu_res;
      out_hi_d = '0;
      flags_d  = alu_flags;
    end else if ((state_q == S_RUN) && mul_done) begin
      out_d    = mul_prod[M:0];
      out_hi_d = mul_prod[2*BITS-1:BITS];
      flags_d  = mul_flags;
    end
  end

  // NOTE: result registers are reset as well, so a reset never leaves a stale value on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign carry_out = flags_q.carry;
  assign zero_flag = flags_q.zero;
  assign neg_flag  = flags_q.neg;
  assign ovf_flag  = flags_q.ovf;

endmodule
